reg_bus_arbiter: RTL

Round-robin arbiter that shares the 16-entry register-file select path among four requesters. Each requester presents a 4-bit register index and a read/write flag; the block grants one requester at a time and drives the registered 4-bit select into the register-select decoder. It also generates the register-in and register-out strobes for a fixed-length transfer window. It sits between the control units (datapath control, debug port, DMA-style loaders) and the register file's select/enable logic.

---
 rtl/reg_bus_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the register-file select path among four requesters.
// Grant, select and strobes appear one edge after an IDLE request; losers hold req until IDLE.
module reg_bus_arbiter #(
  parameter int unsigned HOLD = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [3:0]  req,
  input  logic [15:0] req_idx,
  input  logic [3:0]  req_wr,
  output logic [3:0]  grant,
  output logic [3:0]  sel_out,
  output logic        sel_valid,
  output logic        rin,
  output logic        rout,
  output logic [3:0]  done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  win_q;
  logic [3:0]  cnt_q;
  logic [3:0]  grant_q;
  logic [3:0]  sel_q;
  logic [3:0]  done_q;
  logic        sel_valid_q;
  logic        rin_q;
  logic        rout_q;
  logic        busy_q;

  logic [1:0]  win_d;
  logic [1:0]  cand;
  logic        found;

  // Scan ptr, ptr+1, ... (mod 4); the 2-bit add provides the wrap.
  always_comb begin
    win_d = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        win_d = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      win_q       <= 2'd0;
      cnt_q       <= 4'd0;
      grant_q     <= 4'd0;
      sel_q       <= 4'd0;
      sel_valid_q <= 1'b0;
      rin_q       <= 1'b0;
      rout_q      <= 1'b0;
      done_q      <= 4'd0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q     <= XFER;
            win_q       <= win_d;
            grant_q     <= 4'b0001 << win_d;
            sel_q       <= req_idx[{win_d, 2'b00} +: 4];
            sel_valid_q <= 1'b1;
            // The strobe pair doubles as the latched read/write direction.
            rin_q       <= req_wr[win_d];
            rout_q      <= ~req_wr[win_d];
            cnt_q       <= 4'(HOLD - 1);
            busy_q      <= 1'b1;
          end
        end
        XFER: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            rin_q   <= 1'b0;
            rout_q  <= 1'b0;
            done_q  <= grant_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          ptr_q       <= win_q + 2'd1;
          done_q      <= 4'd0;
          grant_q     <= 4'd0;
          sel_q       <= 4'd0;
          sel_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          grant_q     <= 4'd0;
          sel_q       <= 4'd0;
          sel_valid_q <= 1'b0;
          rin_q       <= 1'b0;
          rout_q      <= 1'b0;
          done_q      <= 4'd0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign sel_out   = sel_q;
  assign sel_valid = sel_valid_q;
  assign rin       = rin_q;
  assign rout      = rout_q;
  assign done      = done_q;
  assign busy      = busy_q;

  a_strobe_excl: assert property (@(posedge clock) disable iff (!clear) !(rin && rout));
  a_grant_1hot:  assert property (@(posedge clock) disable iff (!clear) $onehot0(grant));

endmodule
